// File: rtl/read_ptr_ctrl.sv
// Read-domain pointer and flag controller for an async FIFO: synchronises the write pointer,
// advances the read pointer, and keeps registered empty/almost-empty/level/underflow state.
module read_ptr_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                  R_CLK,
  input  logic                  RST,
  input  logic                  Rinc,
  input  logic [ADDR_WIDTH:0]   W_gray_ptr,
  input  logic                  Rerr_clr,
  output logic [ADDR_WIDTH-1:0] R_addr,
  output logic [ADDR_WIDTH:0]   read_ptr_reg,
  output logic [ADDR_WIDTH:0]   read_ptr_grey,
  output logic                  Rempty,
  output logic                  Ralmost_empty,
  output logic [ADDR_WIDTH:0]   Rlevel,
  output logic                  Runderflow
);

  localparam logic [ADDR_WIDTH:0] AeThresh = (ADDR_WIDTH + 1)'(AE_THRESH);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] wq_q;
  logic [ADDR_WIDTH:0] bin_q, bin_d;
  logic [ADDR_WIDTH:0] gray_q, gray_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                empty_q, empty_d;
  logic                ae_q, ae_d;
  logic                uflow_q, uflow_d;
  logic [ADDR_WIDTH:0] wq_s;
  logic [ADDR_WIDTH:0] wbin_s;
  logic                rd_en;

  assign wq_s = wq_q[SYNC_STAGES-1];

  always_comb begin
    rd_en   = Rinc & ~empty_q;
    bin_d   = bin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    gray_d  = bin_d ^ (bin_d >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    wbin_s = '0;
    for (int i = 0; i <= int'(ADDR_WIDTH); i++) begin
      wbin_s[i] = ^(wq_s >> i);
    end

    // Flags look ahead from next-state pointers so they are valid right after a read.
    level_d = wbin_s - bin_d;
    empty_d = (gray_d == wq_s);
    ae_d    = (level_d <= AeThresh);

    uflow_d = uflow_q;
    if (Rinc && empty_q) begin
      uflow_d = 1'b1;
    end else if (Rerr_clr) begin
      uflow_d = 1'b0;
    end
  end

  always_ff @(posedge R_CLK or posedge RST) begin
    if (RST) begin
      wq_q    <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uflow_q <= 1'b0;
    end else begin
      wq_q[0] <= W_gray_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        wq_q[i] <= wq_q[i-1];
      end
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uflow_q <= uflow_d;
    end
  end

  assign R_addr        = bin_q[ADDR_WIDTH-1:0];
  assign read_ptr_reg  = bin_q;
  assign read_ptr_grey = gray_q;
  assign Rempty        = empty_q;
  assign Ralmost_empty = ae_q;
  assign Rlevel        = level_q;
  assign Runderflow    = uflow_q;

endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Self-checking bench for read_ptr_ctrl: directed scenarios plus a randomized multi-wrap run
// against a FIFO-occupancy reference model.
module tb_read_ptr_ctrl;

  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 2 * DEPTH;

  logic          R_CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Rinc = 1'b0;
  logic          Rerr_clr = 1'b0;
  logic [AW:0]   W_gray_ptr = '0;
  logic [AW-1:0] R_addr;
  logic [AW:0]   read_ptr_reg;
  logic [AW:0]   read_ptr_grey;
  logic          Rempty;
  logic          Ralmost_empty;
  logic [AW:0]   Rlevel;
  logic          Runderflow;

  read_ptr_ctrl #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS),
    .AE_THRESH  (AE)
  ) dut (
    .R_CLK        (R_CLK),
    .RST          (RST),
    .Rinc         (Rinc),
    .W_gray_ptr   (W_gray_ptr),
    .Rerr_clr     (Rerr_clr),
    .R_addr       (R_addr),
    .read_ptr_reg (read_ptr_reg),
    .read_ptr_grey(read_ptr_grey),
    .Rempty       (Rempty),
    .Ralmost_empty(Ralmost_empty),
    .Rlevel       (Rlevel),
    .Runderflow   (Runderflow)
  );

  always #5 R_CLK = ~R_CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: binary write count seen through an SS-deep delay line, and read count.
  int w_bin;
  int m_rp;
  int m_level;
  int m_reads;
  int m_last_rd;
  bit m_empty;
  bit m_ae;
  bit m_uf;
  int m_wpipe[SS];

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_rp = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_ae = 1'b1;
    m_uf = 1'b0;
    m_last_rd = 0;
    for (int i = 0; i < SS; i++) m_wpipe[i] = 0;
  endtask

  task automatic tick();
    int wsync;
    int rd;
    W_gray_ptr = to_gray(w_bin);
    @(posedge R_CLK);
    if (RST) begin
      model_reset();
    end else begin
      rd = (Rinc && !m_empty) ? 1 : 0;
      if (Rinc && m_empty) m_uf = 1'b1;
      else if (Rerr_clr) m_uf = 1'b0;
      m_rp = (m_rp + rd) % MOD;
      m_reads += rd;
      m_last_rd = rd;
      wsync = m_wpipe[SS-1];
      for (int i = SS - 1; i > 0; i--) m_wpipe[i] = m_wpipe[i-1];
      m_wpipe[0] = w_bin;
      m_level = (wsync - m_rp + MOD) % MOD;
      m_empty = (m_level == 0);
      m_ae = (m_level <= AE);
    end
    #1;
  endtask

  task automatic apply_reset();
    Rinc = 1'b0;
    Rerr_clr = 1'b0;
    w_bin = 0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (Rempty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", Rempty); end
    checks++; if (Ralmost_empty !== 1'b1) begin failures++; $display("FAIL reset_ae got=%0b exp=1", Ralmost_empty); end
    checks++; if (Rlevel !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", Rlevel); end
    checks++; if (read_ptr_reg !== '0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", read_ptr_reg); end
    checks++; if (read_ptr_grey !== '0) begin failures++; $display("FAIL reset_grey got=%0h exp=0", read_ptr_grey); end
    checks++; if (Runderflow !== 1'b0) begin failures++; $display("FAIL reset_uf got=%0b exp=0", Runderflow); end
  endtask

  task automatic test_underflow();
    apply_reset();
    Rinc = 1'b1;
    repeat (3) tick();
    Rinc = 1'b0;
    checks++; if (Rempty !== 1'b1) begin failures++; $display("FAIL uf_empty got=%0b exp=1", Rempty); end
    checks++; if (read_ptr_reg !== '0) begin failures++; $display("FAIL uf_ptr_hold got=%0d exp=0", read_ptr_reg); end
    checks++; if (Runderflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", Runderflow); end
    tick();
    checks++; if (Runderflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", Runderflow); end
    Rerr_clr = 1'b1;
    tick();
    Rerr_clr = 1'b0;
    checks++; if (Runderflow !== 1'b0) begin failures++; $display("FAIL uf_clear got=%0b exp=0", Runderflow); end
    // Set wins over clear in the same cycle.
    Rinc = 1'b1;
    Rerr_clr = 1'b1;
    tick();
    Rinc = 1'b0;
    Rerr_clr = 1'b0;
    checks++; if (Runderflow !== 1'b1) begin failures++; $display("FAIL uf_set_prio got=%0b exp=1", Runderflow); end
  endtask

  task automatic test_sync_latency();
    apply_reset();
    w_bin = 1;
    tick();
    checks++; if (Rempty !== 1'b1) begin failures++; $display("FAIL lat_edge1 got=%0b exp=1", Rempty); end
    tick();
    checks++; if (Rempty !== 1'b1) begin failures++; $display("FAIL lat_edge2 got=%0b exp=1", Rempty); end
    tick();
    checks++; if (Rempty !== 1'b0) begin failures++; $display("FAIL lat_edge3 got=%0b exp=0", Rempty); end
    checks++; if (Rlevel !== 5'd1) begin failures++; $display("FAIL lat_level got=%0d exp=1", Rlevel); end
    Rinc = 1'b1;
    tick();
    Rinc = 1'b0;
    checks++; if (read_ptr_grey !== 5'd1) begin failures++; $display("FAIL lat_grey got=%0h exp=1", read_ptr_grey); end
    checks++; if (Rempty !== 1'b1) begin failures++; $display("FAIL lat_reempty got=%0b exp=1", Rempty); end
    checks++; if (Runderflow !== 1'b0) begin failures++; $display("FAIL lat_uf got=%0b exp=0", Runderflow); end
  endtask

  task automatic test_full_drain();
    apply_reset();
    w_bin = DEPTH;
    repeat (SS + 1) tick();
    checks++; if (Rlevel !== 5'(DEPTH)) begin failures++; $display("FAIL full_level got=%0d exp=%0d", Rlevel, DEPTH); end
    checks++; if (Rempty !== 1'b0) begin failures++; $display("FAIL full_empty got=%0b exp=0", Rempty); end
    Rinc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (R_addr !== 4'(i)) begin failures++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", i, R_addr, i); end
      tick();
      checks++; if (Rlevel !== 5'(DEPTH - 1 - i)) begin failures++; $display("FAIL drain_level[%0d] got=%0d exp=%0d", i, Rlevel, DEPTH - 1 - i); end
      checks++; if (Rempty !== (i == DEPTH - 1)) begin failures++; $display("FAIL drain_empty[%0d] got=%0b exp=%0b", i, Rempty, i == DEPTH - 1); end
    end
    Rinc = 1'b0;
    checks++; if (read_ptr_reg !== 5'd16) begin failures++; $display("FAIL drain_ptr got=%0d exp=16", read_ptr_reg); end
    checks++; if (read_ptr_grey !== 5'b11000) begin failures++; $display("FAIL drain_grey got=%b exp=11000", read_ptr_grey); end
    checks++; if (Runderflow !== 1'b0) begin failures++; $display("FAIL drain_uf got=%0b exp=0", Runderflow); end
  endtask

  task automatic test_almost_empty();
    apply_reset();
    w_bin = 4;
    repeat (SS + 1) tick();
    checks++; if (Ralmost_empty !== 1'b0) begin failures++; $display("FAIL ae_lvl4 got=%0b exp=0", Ralmost_empty); end
    Rinc = 1'b1;
    tick();
    checks++; if (Rlevel !== 5'd3 || Ralmost_empty !== 1'b0) begin failures++; $display("FAIL ae_lvl3 got=%0d/%0b exp=3/0", Rlevel, Ralmost_empty); end
    tick();
    Rinc = 1'b0;
    checks++; if (Rlevel !== 5'd2 || Ralmost_empty !== 1'b1) begin failures++; $display("FAIL ae_lvl2 got=%0d/%0b exp=2/1", Rlevel, Ralmost_empty); end
  endtask

  task automatic test_random_wraps();
    logic [AW:0] prev_grey;
    int cycles;
    apply_reset();
    m_reads = 0;
    cycles = 0;
    while (m_reads < 3 * MOD && cycles < 3000) begin
      if ((w_bin - m_rp + MOD) % MOD < DEPTH && $urandom_range(0, 3) != 0) w_bin = (w_bin + 1) % MOD;
      Rinc = ($urandom_range(0, 3) != 0);
      Rerr_clr = ($urandom_range(0, 7) == 0);
      prev_grey = read_ptr_grey;
      tick();
      cycles++;
      checks++; if (read_ptr_reg !== 5'(m_rp)) begin failures++; $display("FAIL rnd_ptr c%0d got=%0d exp=%0d", cycles, read_ptr_reg, m_rp); end
      checks++; if (read_ptr_grey !== to_gray(m_rp)) begin failures++; $display("FAIL rnd_grey c%0d got=%b exp=%b", cycles, read_ptr_grey, to_gray(m_rp)); end
      checks++; if ($countones(prev_grey ^ read_ptr_grey) != m_last_rd) begin failures++; $display("FAIL rnd_hamming c%0d got=%0d exp=%0d", cycles, $countones(prev_grey ^ read_ptr_grey), m_last_rd); end
      checks++; if (R_addr !== 4'(m_rp % DEPTH)) begin failures++; $display("FAIL rnd_addr c%0d got=%0d exp=%0d", cycles, R_addr, m_rp % DEPTH); end
      checks++; if (Rlevel !== 5'(m_level)) begin failures++; $display("FAIL rnd_level c%0d got=%0d exp=%0d", cycles, Rlevel, m_level); end
      checks++; if (Rempty !== m_empty) begin failures++; $display("FAIL rnd_empty c%0d got=%0b exp=%0b", cycles, Rempty, m_empty); end
      checks++; if (Ralmost_empty !== m_ae) begin failures++; $display("FAIL rnd_ae c%0d got=%0b exp=%0b", cycles, Ralmost_empty, m_ae); end
      checks++; if (Runderflow !== m_uf) begin failures++; $display("FAIL rnd_uf c%0d got=%0b exp=%0b", cycles, Runderflow, m_uf); end
    end
    Rinc = 1'b0;
    Rerr_clr = 1'b0;
    checks++; if (m_reads < 3 * MOD) begin failures++; $display("FAIL rnd_budget got=%0d reads exp>=%0d", m_reads, 3 * MOD); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    w_bin = 8;
    repeat (SS + 1) tick();
    Rinc = 1'b1;
    repeat (3) tick();
    // Assert reset between edges and sample before the next clock.
    #1;
    RST = 1'b1;
    #1;
    checks++; if (read_ptr_reg !== '0 || read_ptr_grey !== '0) begin failures++; $display("FAIL rstmid_ptr got=%0d/%0h exp=0/0", read_ptr_reg, read_ptr_grey); end
    checks++; if (Rempty !== 1'b1 || Ralmost_empty !== 1'b1) begin failures++; $display("FAIL rstmid_flags got=%0b/%0b exp=1/1", Rempty, Ralmost_empty); end
    checks++; if (Rlevel !== '0 || Runderflow !== 1'b0) begin failures++; $display("FAIL rstmid_level got=%0d/%0b exp=0/0", Rlevel, Runderflow); end
    Rinc = 1'b0;
    w_bin = 0;
    tick();
    RST = 1'b0;
    w_bin = 5;
    repeat (SS + 1) tick();
    checks++; if (Rlevel !== 5'd5 || Rempty !== 1'b0) begin failures++; $display("FAIL rstmid_refill got=%0d/%0b exp=5/0", Rlevel, Rempty); end
    Rinc = 1'b1;
    repeat (2) tick();
    Rinc = 1'b0;
    checks++; if (read_ptr_reg !== 5'd2 || R_addr !== 4'd2) begin failures++; $display("FAIL rstmid_resume_ptr got=%0d/%0d exp=2/2", read_ptr_reg, R_addr); end
    checks++; if (Rlevel !== 5'd3) begin failures++; $display("FAIL rstmid_resume_level got=%0d exp=3", Rlevel); end
  endtask

  initial begin
    model_reset();
    w_bin = 0;
    m_reads = 0;
    test_reset();
    test_underflow();
    test_sync_latency();
    test_full_drain();
    test_almost_empty();
    test_random_wraps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
